// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-read slave: the first byte of a frame selects a register and
// the following bytes stream out the register file, auto-incrementing with wrap.
module spi_reg_slave #(
    parameter logic [7:0] STATUS_BYTE       = 8'hA5,
    parameter int         NUM_REGS          = 8,
    parameter int         MIN_HALF_BIT_CLKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    input  logic       reg_wr,
    input  logic [2:0] reg_waddr,
    input  logic [7:0] reg_wdata,
    output logic [7:0] cmd_addr,
    output logic       cmd_dv,
    output logic       addr_err,
    output logic [1:0] byte_count,
    output logic       frame_active
);

    // Two sync stages plus one edge-detect stage: SCLK events are seen 3 clks late.
    localparam int SYNC_LATENCY = 3;

    if (MIN_HALF_BIT_CLKS < SYNC_LATENCY) begin : g_half_bit_too_short
        $error("MIN_HALF_BIT_CLKS is shorter than the synchronizer latency");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [1:0]  sclk_sync_r, cs_sync_r, mosi_sync_r;
    logic        sclk_d_r, cs_d_r;
    logic [1:0]  vld_r;
    logic        armed_r;
    logic [7:0]  regs_r [NUM_REGS];
    logic [7:0]  tx_r, rx_r;
    logic [2:0]  bit_cnt_r, ptr_r;
    logic        miso_r, cmd_dv_r, addr_err_r, frame_active_r;
    logic [7:0]  cmd_addr_r;
    logic [1:0]  byte_count_r;
    logic        sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s, byte_done_s;
    logic [7:0]  rx_byte_s;
    logic [2:0]  ptr_inc_s;

    // Input synchronizers, edge-detect history and post-reset arming of CS_n.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_r <= 2'b00;
            cs_sync_r   <= 2'b11;
            mosi_sync_r <= 2'b00;
            sclk_d_r    <= 1'b0;
            cs_d_r      <= 1'b1;
            vld_r       <= 2'b00;
            armed_r     <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[0], i_SPI_Clk};
            cs_sync_r   <= {cs_sync_r[0], i_SPI_CS_n};
            mosi_sync_r <= {mosi_sync_r[0], i_SPI_MOSI};
            sclk_d_r    <= sclk_sync_r[1];
            cs_d_r      <= cs_sync_r[1];
            vld_r       <= {vld_r[0], 1'b1};
            // A frame that was cut by reset must not resume: CS_n has to be seen high first.
            if (vld_r[1] && cs_sync_r[1]) begin
                armed_r <= 1'b1;
            end
        end
    end

    assign sclk_rise_s = sclk_sync_r[1] & ~sclk_d_r;
    assign sclk_fall_s = ~sclk_sync_r[1] & sclk_d_r;
    assign cs_fall_s   = armed_r & cs_d_r & ~cs_sync_r[1];
    assign cs_rise_s   = cs_sync_r[1] & ~cs_d_r;
    assign rx_byte_s   = {rx_r[6:0], mosi_sync_r[1]};
    assign ptr_inc_s   = (ptr_r == 3'(NUM_REGS - 1)) ? 3'd0 : ptr_r + 3'd1;

    // Frame state transitions and byte-completion decode.
    always_comb begin
        state_nxt_s = state_r;
        byte_done_s = 1'b0;
        if ((state_r != ST_IDLE) && !cs_rise_s && sclk_rise_s && (bit_cnt_r == 3'd7)) begin
            byte_done_s = 1'b1;
        end else begin
            byte_done_s = 1'b0;
        end
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) state_nxt_s = ST_ADDR;
                else           state_nxt_s = ST_IDLE;
            end
            ST_ADDR: begin
                if (cs_rise_s)        state_nxt_s = ST_IDLE;
                else if (byte_done_s) state_nxt_s = ST_DATA;
                else                  state_nxt_s = ST_ADDR;
            end
            ST_DATA: begin
                if (cs_rise_s) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_DATA;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nxt_s;
    end

    // System-side register file; a same-edge shift load still sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= 8'h00;
        end else if (reg_wr) begin
            regs_r[reg_waddr] <= reg_wdata;
        end
    end

    // Shift registers, read pointer and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_r           <= 8'h00;
            rx_r           <= 8'h00;
            bit_cnt_r      <= 3'd0;
            ptr_r          <= 3'd0;
            miso_r         <= 1'b0;
            cmd_addr_r     <= 8'h00;
            cmd_dv_r       <= 1'b0;
            addr_err_r     <= 1'b0;
            byte_count_r   <= 2'd0;
            frame_active_r <= 1'b0;
        end else begin
            cmd_dv_r       <= 1'b0;
            addr_err_r     <= 1'b0;
            frame_active_r <= (state_nxt_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        tx_r         <= STATUS_BYTE;
                        miso_r       <= STATUS_BYTE[7];
                        rx_r         <= 8'h00;
                        bit_cnt_r    <= 3'd0;
                        byte_count_r <= 2'd0;
                    end else begin
                        miso_r <= 1'b0;
                    end
                end
                ST_ADDR, ST_DATA: begin
                    if (cs_rise_s) begin
                        miso_r <= 1'b0;
                    end else if (sclk_rise_s) begin
                        rx_r      <= rx_byte_s;
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (byte_done_s) begin
                            if (byte_count_r != 2'd3) byte_count_r <= byte_count_r + 2'd1;
                            if (state_r == ST_ADDR) begin
                                cmd_addr_r <= rx_byte_s;
                                cmd_dv_r   <= 1'b1;
                                ptr_r      <= rx_byte_s[2:0];
                                if (rx_byte_s[7:3] == 5'd0) begin
                                    tx_r <= regs_r[rx_byte_s[2:0]];
                                end else begin
                                    tx_r       <= 8'hFF;
                                    addr_err_r <= 1'b1;
                                end
                            end else begin
                                ptr_r <= ptr_inc_s;
                                tx_r  <= regs_r[ptr_inc_s];
                            end
                        end
                    end else if (sclk_fall_s) begin
                        // Right after a byte boundary the freshly loaded MSB goes out unshifted.
                        if (bit_cnt_r == 3'd0) begin
                            miso_r <= tx_r[7];
                        end else begin
                            miso_r <= tx_r[6];
                            tx_r   <= {tx_r[6:0], 1'b0};
                        end
                    end
                end
                default: miso_r <= 1'b0;
            endcase
        end
    end

    assign o_SPI_MISO   = miso_r;
    assign cmd_addr     = cmd_addr_r;
    assign cmd_dv       = cmd_dv_r;
    assign addr_err     = addr_err_r;
    assign byte_count   = byte_count_r;
    assign frame_active = frame_active_r;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Self-checking bench for spi_reg_slave: directed scenarios with literal expectations
// followed by randomized frames compared against a register-file model.
module tb_spi_reg_slave;

    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_SPI_Clk = 1'b0;
    logic       i_SPI_CS_n = 1'b1;
    logic       i_SPI_MOSI = 1'b0;
    logic       o_SPI_MISO;
    logic       reg_wr = 1'b0;
    logic [2:0] reg_waddr = 3'd0;
    logic [7:0] reg_wdata = 8'h00;
    logic [7:0] cmd_addr;
    logic       cmd_dv;
    logic       addr_err;
    logic [1:0] byte_count;
    logic       frame_active;

    spi_reg_slave dut (
        .clk(clk), .rst(rst), .i_SPI_Clk(i_SPI_Clk), .i_SPI_CS_n(i_SPI_CS_n),
        .i_SPI_MOSI(i_SPI_MOSI), .o_SPI_MISO(o_SPI_MISO), .reg_wr(reg_wr),
        .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .cmd_addr(cmd_addr),
        .cmd_dv(cmd_dv), .addr_err(addr_err), .byte_count(byte_count),
        .frame_active(frame_active)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         fails = 0;
    int         dv_cnt = 0;
    int         err_cnt = 0;
    logic       idle_chk = 1'b0;
    logic [7:0] exp_addr = 8'h00;
    logic [7:0] last_addr = 8'h00;
    logic [7:0] regs_m [8];
    logic [7:0] tx_bytes [4];
    logic [7:0] rx_bytes [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare: pulse bookkeeping, cmd_addr at each valid, idle invariants.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cmd_dv) begin
                    dv_cnt++;
                    chk("cmd_addr_at_dv", 32'(cmd_addr), 32'(exp_addr));
                end
                if (addr_err) err_cnt++;
                if (idle_chk) begin
                    chk("idle_miso", 32'(o_SPI_MISO), 32'd0);
                    chk("idle_frame_active", 32'(frame_active), 32'd0);
                end
            end
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [7:0] addr, input int k);
        if (k == 0) return 8'hA5;
        if (k == 1 && addr[7:3] != 5'd0) return 8'hFF;
        return regs_m[(int'(addr[2:0]) + k - 1) % 8];
    endfunction

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        reg_wr = 1'b1; reg_waddr = a; reg_wdata = d;
        @(negedge clk);
        reg_wr = 1'b0;
        regs_m[a] = d;
    endtask

    task automatic clock_bits(input int nbits, input logic collide);
        for (int i = 0; i < nbits; i++) begin
            i_SPI_MOSI = tx_bytes[i / 8][7 - (i % 8)];
            repeat (HALF) @(negedge clk);
            rx_bytes[i / 8][7 - (i % 8)] = o_SPI_MISO;
            i_SPI_Clk = 1'b1;
            if (collide && i == 7) begin
                // Two clks of sync plus one of edge detect puts the load on the third edge.
                @(negedge clk);
                @(negedge clk);
                reg_wr = 1'b1; reg_waddr = 3'd2; reg_wdata = 8'h99;
                @(negedge clk);
                reg_wr = 1'b0;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            i_SPI_Clk = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] addr, input int nbits, input logic collide);
        tx_bytes[0] = addr;
        exp_addr = addr;
        dv_cnt = 0; err_cnt = 0; idle_chk = 1'b0;
        for (int k = 0; k < 4; k++) rx_bytes[k] = 8'h00;
        i_SPI_CS_n = 1'b0;
        repeat (HALF) @(negedge clk);
        chk("frame_active_in_frame", 32'(frame_active), 32'd1);
        clock_bits(nbits, collide);
        repeat (HALF) @(negedge clk);
        i_SPI_CS_n = 1'b1;
        repeat (6) @(negedge clk);
        idle_chk = 1'b1;
    endtask

    // Compare a finished frame against the model and advance the model's cmd_addr.
    task automatic check_frame(input logic [7:0] addr, input int nbits);
        int complete = nbits / 8;
        for (int k = 0; k < complete; k++) chk("miso_byte", 32'(rx_bytes[k]), 32'(model_byte(addr, k)));
        chk("dv_count", 32'(dv_cnt), (complete >= 1) ? 32'd1 : 32'd0);
        chk("err_count", 32'(err_cnt), (complete >= 1 && addr[7:3] != 5'd0) ? 32'd1 : 32'd0);
        if (complete >= 1) last_addr = addr;
        chk("cmd_addr_hold", 32'(cmd_addr), 32'(last_addr));
        chk("byte_count", 32'(byte_count), (complete > 3) ? 32'd3 : 32'(complete));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_miso"}, 32'(o_SPI_MISO), 32'd0);
        chk({tag, "_cmd_addr"}, 32'(cmd_addr), 32'd0);
        chk({tag, "_cmd_dv"}, 32'(cmd_dv), 32'd0);
        chk({tag, "_addr_err"}, 32'(addr_err), 32'd0);
        chk({tag, "_byte_count"}, 32'(byte_count), 32'd0);
        chk({tag, "_frame_active"}, 32'(frame_active), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) regs_m[k] = 8'h00;
        for (int k = 0; k < 4; k++) tx_bytes[k] = 8'h00;
        fork
            monitor();
        join_none
        #1;
        check_all_zero("reset");
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        idle_chk = 1'b1;

        // Basic read of a preloaded register.
        wr(3'd3, 8'h3C);
        run_frame(8'h03, 16, 1'b0);
        chk("basic_b0", 32'(rx_bytes[0]), 32'h0000_00A5);
        chk("basic_b1", 32'(rx_bytes[1]), 32'h0000_003C);
        chk("basic_cmd_addr", 32'(cmd_addr), 32'h0000_0003);
        chk("basic_dv", 32'(dv_cnt), 32'd1);
        chk("basic_count", 32'(byte_count), 32'd2);
        last_addr = 8'h03;

        // Auto-increment wrapping from reg 7 to reg 0.
        wr(3'd7, 8'h77);
        wr(3'd0, 8'h11);
        run_frame(8'h07, 24, 1'b0);
        chk("wrap_b1", 32'(rx_bytes[1]), 32'h0000_0077);
        chk("wrap_b2", 32'(rx_bytes[2]), 32'h0000_0011);
        chk("wrap_count", 32'(byte_count), 32'd3);
        check_frame(8'h07, 24);

        // Out-of-range address.
        run_frame(8'h1F, 16, 1'b0);
        chk("bad_b1", 32'(rx_bytes[1]), 32'h0000_00FF);
        chk("bad_err", 32'(err_cnt), 32'd1);
        chk("bad_cmd_addr", 32'(cmd_addr), 32'h0000_001F);
        check_frame(8'h1F, 16);

        // Abort after five address bits.
        run_frame(8'h05, 5, 1'b0);
        chk("abort_dv", 32'(dv_cnt), 32'd0);
        chk("abort_cmd_addr", 32'(cmd_addr), 32'h0000_001F);
        chk("abort_count", 32'(byte_count), 32'd0);

        // Write colliding with the shift-register load of the same register.
        wr(3'd2, 8'h22);
        run_frame(8'h02, 16, 1'b1);
        chk("collide_old", 32'(rx_bytes[1]), 32'h0000_0022);
        regs_m[2] = 8'h99;
        last_addr = 8'h02;
        run_frame(8'h02, 16, 1'b0);
        chk("collide_new", 32'(rx_bytes[1]), 32'h0000_0099);

        // Reset in the middle of a data byte.
        wr(3'd5, 8'hFF);
        tx_bytes[0] = 8'h05;
        exp_addr = 8'h05;
        idle_chk = 1'b0;
        i_SPI_CS_n = 1'b0;
        repeat (HALF) @(negedge clk);
        clock_bits(11, 1'b0);
        repeat (HALF) @(negedge clk);
        chk("pre_reset_miso", 32'(o_SPI_MISO), 32'd1);
        #2 rst = 1'b1;
        #1 check_all_zero("midframe_reset");
        for (int k = 0; k < 8; k++) regs_m[k] = 8'h00;
        last_addr = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        dv_cnt = 0;
        idle_chk = 1'b1;
        clock_bits(8, 1'b0);
        repeat (HALF) @(negedge clk);
        i_SPI_CS_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("no_resume_dv", 32'(dv_cnt), 32'd0);
        chk("no_resume_count", 32'(byte_count), 32'd0);
        run_frame(8'h05, 16, 1'b0);
        chk("post_reset_b0", 32'(rx_bytes[0]), 32'h0000_00A5);
        chk("post_reset_b1", 32'(rx_bytes[1]), 32'h0000_0000);
        check_frame(8'h05, 16);

        // Randomized frames against the model.
        for (int f = 0; f < 40; f++) begin
            logic [7:0] a;
            int nb;
            for (int w = 0; w < int'($urandom_range(0, 3)); w++)
                wr(3'($urandom_range(0, 7)), 8'($urandom));
            if ($urandom_range(0, 3) != 0) a = 8'($urandom_range(0, 7));
            else                           a = 8'($urandom_range(8, 255));
            if ($urandom_range(0, 4) == 0) begin
                nb = int'($urandom_range(1, 31));
                if (nb % 8 == 0) nb++;
            end else begin
                nb = 8 * int'($urandom_range(1, 4));
            end
            for (int k = 1; k < 4; k++) tx_bytes[k] = 8'($urandom);
            run_frame(a, nb, 1'b0);
            check_frame(a, nb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
